// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and FSM encoding for the LC2K data-memory path
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_MEM = 1'b1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant; the last winner loses the next tie
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_valid,
  output logic o_grant
);
  logic r_last;
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = (i_req0 & i_req1) ? ~r_last : (i_req1 ? PORT_MEM : PORT_FETCH);
  end
  always_ff @(posedge clk) begin
    if (reset) r_last <= PORT_FETCH;
    else if (i_en && o_valid) r_last <= o_grant;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data memory between instruction fetch
// (port 0) and load/store (port 1) with round-robin arbitration
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] aluResult,
  output logic [DATA_W-1:0] regBvalue,
  output logic              CONTROL_MEM_ACCESS,
  output logic              CONTROL_ENABLE_MEM_WRITE,
  input  logic [DATA_W-1:0] memResult
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_grant, w_valid, w_grant, w_idle, w_done;
  assign w_idle = r_state == IDLE;
  assign w_done = r_state == ACCESS && r_cnt == '0;
  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_idle),
    .i_req0 (req0),
    .i_req1 (req1),
    .o_valid(w_valid),
    .o_grant(w_grant)
  );
  always_comb begin
    w_next = IDLE;
    if (w_idle) w_next = w_valid ? ACCESS : IDLE;
    else if (r_state == ACCESS) w_next = w_done ? DONE : ACCESS;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // The ack is registered off the last ACCESS cycle so it lands in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt                    <= '0;
      r_grant                  <= PORT_FETCH;
      ack0                     <= 1'b0;
      ack1                     <= 1'b0;
      rdata                    <= '0;
      aluResult                <= '0;
      regBvalue                <= '0;
      CONTROL_MEM_ACCESS       <= 1'b0;
      CONTROL_ENABLE_MEM_WRITE <= 1'b0;
    end else begin
      ack0 <= w_done && r_grant == PORT_FETCH;
      ack1 <= w_done && r_grant == PORT_MEM;
      if (w_idle && w_valid) begin
        r_grant                  <= w_grant;
        aluResult                <= w_grant ? addr1 : addr0;
        regBvalue                <= w_grant ? wdata1 : wdata0;
        CONTROL_ENABLE_MEM_WRITE <= w_grant ? we1 : we0;
        CONTROL_MEM_ACCESS       <= 1'b1;
        r_cnt                    <= CNT_W'(MEM_LATENCY - 1);
      end else if (w_done) begin
        if (!CONTROL_ENABLE_MEM_WRITE) rdata <= memResult;
        CONTROL_MEM_ACCESS       <= 1'b0;
        CONTROL_ENABLE_MEM_WRITE <= 1'b0;
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter at latencies 1 and 4
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic req0[2], req1[2], we0[2], we1[2], ack0[2], ack1[2], cma[2], cmw[2];
  logic [31:0] addr0[2], addr1[2], wd0[2], wd1[2], rd[2], alu[2], regb[2], mres[2];
  logic [31:0] mem[2][32];
  logic pk_en, pk_k;
  logic [4:0] pk_a;
  logic [31:0] pk_d;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wd0[0]), .wdata1(wd1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .rdata(rd[0]), .aluResult(alu[0]), .regBvalue(regb[0]),
    .CONTROL_MEM_ACCESS(cma[0]), .CONTROL_ENABLE_MEM_WRITE(cmw[0]), .memResult(mres[0])
  );
  mem_arbiter #(.MEM_LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wd0[1]), .wdata1(wd1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .rdata(rd[1]), .aluResult(alu[1]), .regBvalue(regb[1]),
    .CONTROL_MEM_ACCESS(cma[1]), .CONTROL_ENABLE_MEM_WRITE(cmw[1]), .memResult(mres[1])
  );

  // Behavioural single-port memory: combinational read, write while access+write held
  assign mres[0] = mem[0][alu[0][4:0]];
  assign mres[1] = mem[1][alu[1][4:0]];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (cma[k] && cmw[k]) mem[k][alu[k][4:0]] <= regb[k];
    if (pk_en) mem[pk_k][pk_a] <= pk_d;
  end

  task automatic poke(input logic k, input logic [4:0] a, input logic [31:0] d);
    pk_en = 1'b1; pk_k = k; pk_a = a; pk_d = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      req0[k] = 0; req1[k] = 0; we0[k] = 0; we1[k] = 0;
      addr0[k] = 0; addr1[k] = 0; wd0[k] = 0; wd1[k] = 0;
    end
  endtask

  task automatic wait_ack(input int k, input bit p, input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if ((p ? ack1[k] : ack0[k]) === 1'b1) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    pk_en = 1'b0; pk_k = 1'b0; pk_a = '0; pk_d = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if ({ack0[k], ack1[k], cma[k], cmw[k]} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl[%0d]: got %b expected 0000", k, {ack0[k], ack1[k], cma[k], cmw[k]}); end
      n_cmp++; if (rd[k] !== 32'd0) begin n_err++; $display("FAIL reset_rdata[%0d]: got %0h expected 0", k, rd[k]); end
      n_cmp++; if (alu[k] !== 32'd0 || regb[k] !== 32'd0) begin n_err++; $display("FAIL reset_addr[%0d]: got %0h/%0h expected 0/0", k, alu[k], regb[k]); end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    poke(0, 5'd3, 32'd33);
    poke(0, 5'd4, 32'd44);
    req0[0] = 1; addr0[0] = 3; req1[0] = 1; addr1[0] = 4;
    for (int c = 1; c <= 11; c++) begin
      bit e0, e1;
      @(negedge clk);
      e1 = (c % 3 == 2) && ((c / 3) % 2 == 0);
      e0 = (c % 3 == 2) && ((c / 3) % 2 == 1);
      n_cmp++; if (ack0[0] !== e0 || ack1[0] !== e1) begin n_err++; $display("FAIL tie_ack c=%0d: got %b%b expected %b%b", c, ack1[0], ack0[0], e1, e0); end
      n_cmp++; if (cma[0] !== (c % 3 == 1)) begin n_err++; $display("FAIL tie_cma c=%0d: got %b expected %b", c, cma[0], c % 3 == 1); end
      if (e0 || e1) begin
        n_cmp++; if (rd[0] !== (e1 ? 32'd44 : 32'd33)) begin n_err++; $display("FAIL tie_rdata c=%0d: got %0d expected %0d", c, rd[0], e1 ? 44 : 33); end
      end
    end
    req0[0] = 0; req1[0] = 0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    poke(0, 5'd10, 32'd5);
    req0[0] = 1; addr0[0] = 10; we0[0] = 0;
    @(negedge clk);
    n_cmp++; if (cma[0] !== 1'b1 || alu[0] !== 32'd10) begin n_err++; $display("FAIL read_c1: got cma=%b addr=%0d expected cma=1 addr=10", cma[0], alu[0]); end
    n_cmp++; if (ack0[0] !== 1'b0) begin n_err++; $display("FAIL read_early_ack: got %b expected 0", ack0[0]); end
    addr0[0] = 9;
    @(negedge clk);
    n_cmp++; if (ack0[0] !== 1'b1 || ack1[0] !== 1'b0) begin n_err++; $display("FAIL read_ack: got ack0=%b ack1=%b expected 1/0", ack0[0], ack1[0]); end
    n_cmp++; if (rd[0] !== 32'd5 || alu[0] !== 32'd10) begin n_err++; $display("FAIL read_data: got rdata=%0d addr=%0d expected 5/10", rd[0], alu[0]); end
    req0[0] = 0;
    @(negedge clk);
  endtask

  task automatic test_write_readback();
    int cyc;
    req1[0] = 1; we1[0] = 1; addr1[0] = 20; wd1[0] = 32'hDEADBEEF;
    wait_ack(0, 1, 10, cyc);
    n_cmp++; if (cyc != 2) begin n_err++; $display("FAIL write_ack_cycle: got %0d expected 2", cyc); end
    n_cmp++; if (rd[0] !== 32'd5) begin n_err++; $display("FAIL write_keeps_rdata: got %0h expected 5", rd[0]); end
    n_cmp++; if (regb[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_regb: got %0h expected deadbeef", regb[0]); end
    we1[0] = 0; wd1[0] = 0;
    wait_ack(0, 1, 10, cyc);
    n_cmp++; if (cyc != 3) begin n_err++; $display("FAIL readback_cycle: got %0d expected 3", cyc); end
    n_cmp++; if (rd[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL readback_data: got %0h expected deadbeef", rd[0]); end
    req1[0] = 0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    poke(1, 5'd9, 32'd1);
    poke(1, 5'd10, 32'd5);
    req0[1] = 1; addr0[1] = 9; we0[1] = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++; if (cma[1] !== (c <= 4)) begin n_err++; $display("FAIL lat_cma c=%0d: got %b expected %b", c, cma[1], c <= 4); end
      n_cmp++; if (ack0[1] !== (c == 5) || ack1[1] !== 1'b0) begin n_err++; $display("FAIL lat_ack c=%0d: got %b%b expected 0%b", c, ack1[1], ack0[1], c == 5); end
      if (c == 5) begin
        n_cmp++; if (rd[1] !== 32'd1) begin n_err++; $display("FAIL lat_rdata: got %0d expected 1", rd[1]); end
        req0[1] = 0;
      end
    end
  endtask

  task automatic test_mid_change();
    req0[1] = 1; addr0[1] = 10; we0[1] = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        n_cmp++; if (alu[1] !== 32'd10 || cmw[1] !== 1'b0) begin n_err++; $display("FAIL mid_hold c=%0d: got addr=%0d we=%b expected 10/0", c, alu[1], cmw[1]); end
      end
      if (c == 1) begin addr0[1] = 9; we0[1] = 1; wd0[1] = 32'h1234; end
      if (c == 5) begin
        n_cmp++; if (ack0[1] !== 1'b1 || rd[1] !== 32'd5) begin n_err++; $display("FAIL mid_result: got ack=%b rdata=%0d expected 1/5", ack0[1], rd[1]); end
        req0[1] = 0; we0[1] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req0[1] = 1; addr0[1] = 9; we0[1] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1; req0[1] = 0;
    @(negedge clk);
    n_cmp++; if (cma[1] !== 1'b0 || rd[1] !== 32'd0) begin n_err++; $display("FAIL rstmid_clear: got cma=%b rdata=%0h expected 0/0", cma[1], rd[1]); end
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++; if (ack0[1] !== 1'b0 || ack1[1] !== 1'b0) begin n_err++; $display("FAIL rstmid_no_ack c=%0d: got %b%b expected 00", c, ack1[1], ack0[1]); end
    end
    poke(1, 5'd4, 32'd8);
    req0[1] = 1; addr0[1] = 3; req1[1] = 1; addr1[1] = 4;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (ack1[1] !== (c == 5) || ack0[1] !== 1'b0) begin n_err++; $display("FAIL rstmid_tie c=%0d: got %b%b expected %b0", c, ack1[1], ack0[1], c == 5); end
    end
    n_cmp++; if (rd[1] !== 32'd8) begin n_err++; $display("FAIL rstmid_tie_data: got %0d expected 8", rd[1]); end
    req0[1] = 0; req1[1] = 0;
    @(negedge clk);
  endtask

  // Transaction-level model: IDLE slot every L+2 cycles when busy, rr on ties
  task automatic test_random(input int k);
    int lat = k ? 4 : 1;
    logic [31:0] mmod[32];
    bit pend[2], op_we[2], g_we, last, g_p, w;
    logic [4:0] op_a[2], g_a;
    logic [31:0] op_d[2], g_d, rd_exp;
    int g_at = -100, ack_at = -1, free_at = 0;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      mmod[a] = $urandom;
      poke(k[0], 5'(a), mmod[a]);
    end
    pend = '{0, 0}; last = 0; g_p = 0; g_we = 0; g_a = 0; g_d = 0; rd_exp = 0;
    for (int n = 0; n < 300; n++) begin
      bit e_cma;
      if (n == ack_at) begin
        if (g_we) mmod[g_a] = g_d; else rd_exp = mmod[g_a];
        pend[g_p] = 0;
      end
      e_cma = n > g_at && n <= g_at + lat;
      n_cmp++; if (ack0[k] !== (n == ack_at && !g_p) || ack1[k] !== (n == ack_at && g_p)) begin n_err++; $display("FAIL rnd%0d_ack n=%0d: got %b%b expected %b%b", k, n, ack1[k], ack0[k], n == ack_at && g_p, n == ack_at && !g_p); end
      n_cmp++; if (rd[k] !== rd_exp) begin n_err++; $display("FAIL rnd%0d_rdata n=%0d: got %0h expected %0h", k, n, rd[k], rd_exp); end
      n_cmp++; if (cma[k] !== e_cma || cmw[k] !== (e_cma && g_we)) begin n_err++; $display("FAIL rnd%0d_ctrl n=%0d: got %b%b expected %b%b", k, n, cma[k], cmw[k], e_cma, e_cma && g_we); end
      if (e_cma) begin
        n_cmp++; if (alu[k] !== {27'd0, g_a} || regb[k] !== g_d) begin n_err++; $display("FAIL rnd%0d_bus n=%0d: got %0h/%0h expected %0h/%0h", k, n, alu[k], regb[k], g_a, g_d); end
      end
      for (int p = 0; p < 2; p++) begin
        bit scr = pend[p] && g_p == p[0] && n > g_at && n < ack_at;
        if (!pend[p] && $urandom_range(1) == 1) begin
          pend[p] = 1; op_we[p] = 1'($urandom_range(1)); op_a[p] = 5'($urandom_range(31)); op_d[p] = $urandom;
        end
        if (p == 0) begin
          req0[k] = pend[0]; we0[k] = scr ? 1'($urandom_range(1)) : op_we[0];
          addr0[k] = scr ? {27'd0, 5'($urandom_range(31))} : {27'd0, op_a[0]}; wd0[k] = scr ? $urandom : op_d[0];
        end else begin
          req1[k] = pend[1]; we1[k] = scr ? 1'($urandom_range(1)) : op_we[1];
          addr1[k] = scr ? {27'd0, 5'($urandom_range(31))} : {27'd0, op_a[1]}; wd1[k] = scr ? $urandom : op_d[1];
        end
      end
      if (n == free_at) begin
        if (pend[0] || pend[1]) begin
          w = (pend[0] && pend[1]) ? !last : pend[1];
          g_p = w; g_we = op_we[w]; g_a = op_a[w]; g_d = op_d[w];
          g_at = n; ack_at = n + lat + 1; free_at = n + lat + 2; last = w;
        end else free_at = n + 1;
      end
      @(negedge clk);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_write_readback();
    test_latency();
    test_mid_change();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: instruction fetch (port 0) and load/store (port 1) of the LC2K CPU.
- Arbitrates with round-robin, latches the winning request, and drives the memory access/write controls for a fixed MEM_LATENCY.
- Returns read data with a one-cycle ack pulse to the winner.
- Sits between the fetch/execute stages and the data memory; the memory itself is unchanged.

Parameters:
- DATA_W, 32, data and address width.
- MEM_LATENCY, 1, cycles the memory controls are held per access; legal range 1..15.
- CNT_W, 4, width of the latency down-counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request from port 0 / port 1; held high until that port's ack.
- we0, we1  in  1  1 = write, 0 = read; valid while the matching req is high.
- addr0, addr1  in  DATA_W  word address.
- wdata0, wdata1  in  DATA_W  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read result; valid in the ack cycle and held until the next read completes.
- aluResult  out  DATA_W  address to memory (latched).
- regBvalue  out  DATA_W  write data to memory (latched).
- CONTROL_MEM_ACCESS  out  1  memory access enable.
- CONTROL_ENABLE_MEM_WRITE  out  1  1 = write, 0 = read.
- memResult  in  DATA_W  memory read data.

Behaviour:
- All outputs are registered.
- Reset values:
  - ack0, ack1, CONTROL_MEM_ACCESS, CONTROL_ENABLE_MEM_WRITE = 0.
  - rdata, aluResult, regBvalue = 0.
  - state = IDLE; counter = 0; last_grant = 0, so port 1 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port not equal to last_grant.
  - On a grant:
    - Latch addr, wdata and we into aluResult, regBvalue and CONTROL_ENABLE_MEM_WRITE.
    - Set CONTROL_MEM_ACCESS = 1, counter = MEM_LATENCY-1, record the winner in last_grant.
    - Go to ACCESS.
- ACCESS:
  - Memory controls are held constant.
  - When counter = 0:
    - On a read, capture memResult into rdata.
    - Clear CONTROL_MEM_ACCESS and CONTROL_ENABLE_MEM_WRITE.
    - Pulse ack of the granted port (asserted in DONE).
    - Go to DONE.
  - Otherwise decrement the counter.
- DONE:
  - The ack is high for exactly this one cycle.
  - Next state is always IDLE; no grant is made in DONE.
- Latency:
  - Request sampled in IDLE at cycle t.
  - CONTROL_MEM_ACCESS is high for cycles t+1 .. t+MEM_LATENCY.
  - ack is high at t+MEM_LATENCY+1.
  - Peak throughput is one access per MEM_LATENCY+2 cycles.
- Inputs of the granted port are ignored after the grant; changes mid-access have no effect.
- Inputs of the losing port are ignored until the next IDLE. A req still high in IDLE after DONE is a new request.
- Round-robin guarantees no port waits more than one foreign access while continuously requesting.
- A write leaves rdata unchanged.
- Reset mid-operation:
  - Next edge forces IDLE and clears the memory controls; no ack is issued.
  - rdata is cleared and last_grant returns to 0.
  - Write completion in the memory is not guaranteed.
- ack0 and ack1 are never high together.
- CONTROL_ENABLE_MEM_WRITE is never high without CONTROL_MEM_ACCESS.

Decomposition:
- Shared package cpu_pkg holds:
  - The state encoding enum (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
  - The DATA_W constant.
  - PORT_FETCH=0 and PORT_MEM=1 constants.
- One natural sub-module, rr_arbiter2: a 2-input round-robin grant with a last_grant register and enable. Everything else is flat.

Test Plan:
- Single read: MEM_LATENCY=1, memory word 10 = 5; req0=1, addr0=10, we0=0 at cycle 0 -> CONTROL_MEM_ACCESS=1 and aluResult=10 in cycle 1; ack0=1 and rdata=5 in cycle 2; ack1 stays 0.
- Write then read-back: req1, we1=1, addr1=20, wdata1=0xDEADBEEF, held until ack1. Then req1 read of addr1=20 -> rdata=0xDEADBEEF. rdata is unchanged during the write's ack.
- Tie after reset: req0 and req1 both high at cycle 0 -> port 1 is granted first (ack1 at cycle 2). Port 0 is granted in the following IDLE (cycle 3, ack0 at cycle 5). Held requests continue to alternate 1,0,1,0.
- Latency parameter: MEM_LATENCY=4, read of word 9 = 1 -> CONTROL_MEM_ACCESS high for exactly 4 cycles; ack 5 cycles after the request is sampled; rdata=1.
- Mid-access input change: after grant, change addr0 from 10 to 9 -> aluResult stays 10 and rdata=5.
- Reset mid-access: MEM_LATENCY=4, assert reset in the 2nd ACCESS cycle -> next edge has CONTROL_MEM_ACCESS=0 and rdata=0; no ack pulse in the following 6 cycles with req low. A subsequent tie is granted to port 1.
